rom_reader: RTL and testbench

Streaming read engine for the synchronous single-port ROM. It sweeps a programmed address range, absorbs the memory's one-cycle read latency, and presents the words as a valid/ready stream with full backpressure and a last-beat marker. It sits between the ROM and any consumer that needs table or pattern contents delivered as a stream: coefficient loaders, test-pattern sources and boot sequencers.

---
 rtl/rom_reader_pkg.sv | 13 +
 rtl/rom_reader_fifo2.sv | 67 ++++++
 rtl/rom_reader.sv | 113 +++++++++++
 tb/tb_rom_reader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and sizing for the ROM streaming reader.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_reader_fifo2.sv
// Two-entry synchronous FIFO with a registered head; clr_i empties it and zeroes the head.
module fifo2
  import rom_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             pop_eff;

  assign pop_eff = pop_i && (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push_i, pop_eff})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = wdata_i;
        else                 slot1_d = wdata_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Emptying zeroes the head so idle outputs read back as 0.
        slot0_d = (count_q == 2'(FIFO_DEPTH)) ? slot1_q : '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'(FIFO_DEPTH)) begin
          slot0_d = slot1_q;
          slot1_d = wdata_i;
        end else begin
          slot0_d = wdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = slot0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/rom_reader.sv
// Sweeps a ROM address range and streams the words out over valid/ready with a last marker.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [2:0]            limit;
  logic                  room_ok;

  assign pop = tvalid_o && tready_i;

  // Room check: slots held or promised after this cycle's pop, plus the new request.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} + 3'd1;
  assign limit     = 3'(FIFO_DEPTH) + {2'b00, pop};
  assign room_ok   = (occupancy <= limit);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d  = ISSUE;
            addr_d   = base_addr_i;
            remain_d = len_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (room_ok) begin
          inflight_d      = 1'b1;
          inflight_last_d = (remain_q == (ADDR_WIDTH+1)'(1));
          addr_d          = addr_q + 1'b1;
          remain_d        = remain_q - 1'b1;
          if (remain_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && tlast_o) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .push_i (inflight_q),
    .wdata_i({inflight_last_q, mem_data_i}),
    .pop_i  (pop),
    .rdata_o(fifo_head),
    .valid_o(tvalid_o),
    .count_o(fifo_count)
  );

  assign tdata_o    = fifo_head[DATA_WIDTH-1:0];
  assign tlast_o    = fifo_head[DATA_WIDTH];
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_rom_reader.sv
// Directed vector bench for rom_reader against a ROM whose word equals its address.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst_i, start_i, tready_i;
  logic [7:0] base_addr_i, mem_addr_o, mem_data_i, tdata_o;
  logic [8:0] len_i;
  logic       busy_o, done_o, tvalid_o, tlast_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous ROM model, one-cycle latency, mem[a] = a.
  always @(posedge clk) mem_data_i <= mem_addr_o;

  rom_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .tdata_o    (tdata_o),
    .tvalid_o   (tvalid_o),
    .tready_i   (tready_i),
    .tlast_o    (tlast_o)
  );

  typedef struct {
    logic [7:0] base;
    int         len;
    int         mode;      // 0: tready always 1, 1: 1-on/2-off then random
    bit         poke;      // pulse start_i mid-sweep
    logic [7:0] exp_last;  // data on the tlast beat
    int         exp_beats;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit pick_ready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (k < 40) return (k % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_vec(input vec_t v);
    logic [7:0] bd[$];
    bit         bl[$];
    int         bc[$];
    int         done_cyc = -1;
    int         busy_bad = 0;
    int         stab_bad = 0;
    bit         held = 1'b0;
    logic [7:0] hd = 8'h00;
    bit         hl = 1'b0;
    logic [7:0] e;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = v.base; len_i = 9'(v.len); tready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; base_addr_i = 8'h00; len_i = 9'd0;
    for (int k = 1; k <= 2000; k++) begin
      tready_i = pick_ready(v.mode, k);
      if (v.poke && k == 5) begin
        start_i = 1'b1; base_addr_i = 8'hAA; len_i = 9'd3;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      if (held && (!tvalid_o || tdata_o != hd || tlast_o != hl)) stab_bad++;
      held = tvalid_o && !tready_i;
      hd = tdata_o;
      hl = tlast_o;
      if (tvalid_o && tready_i) begin
        bd.push_back(tdata_o); bl.push_back(tlast_o); bc.push_back(k);
      end
      if (!busy_o) busy_bad++;
      if (done_o) begin
        done_cyc = k;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("done_one_cycle", int'(done_o), 0);
        check("busy_falls", int'(busy_o), 0);
        break;
      end
      @(posedge clk); #1;
    end
    check("sweep_finished", int'(done_cyc >= 0), 1);
    check("beat_count", bd.size(), v.exp_beats);
    for (int i = 0; i < bd.size(); i++) begin
      e = v.base + 8'(i);
      check($sformatf("beat%0d_data", i), int'(bd[i]), int'(e));
      check($sformatf("beat%0d_last", i), int'(bl[i]), int'(i == bd.size() - 1));
    end
    if (bd.size() > 0) check("last_beat_data", int'(bd[bd.size()-1]), int'(v.exp_last));
    if (v.mode == 0 && v.len > 0 && bc.size() > 0) begin
      check("first_beat_cycle", bc[0], 3);
      check("last_beat_cycle", bc[bc.size()-1], v.len + 2);
    end
    if (done_cyc >= 0)
      check("done_cycle", done_cyc, (bc.size() == 0) ? 1 : bc[bc.size()-1] + 1);
    check("busy_while_active", busy_bad, 0);
    check("hold_stable", stab_bad, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int seen;
    int vbad;
    vecs[0] = '{8'h10, 4,   0, 1'b0, 8'h13, 4};
    vecs[1] = '{8'hFE, 4,   0, 1'b0, 8'h01, 4};
    vecs[2] = '{8'h00, 16,  1, 1'b0, 8'h0F, 16};
    vecs[3] = '{8'h80, 256, 0, 1'b0, 8'h7F, 256};
    vecs[4] = '{8'h33, 0,   0, 1'b0, 8'h00, 0};
    vecs[5] = '{8'h40, 6,   0, 1'b1, 8'h45, 6};
    vecs[6] = '{8'h07, 1,   0, 1'b0, 8'h07, 1};

    rst_i = 1'b1; start_i = 1'b0; base_addr_i = 8'h00; len_i = 9'd0; tready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_tvalid", int'(tvalid_o), 0);
    check("rst_tlast", int'(tlast_o), 0);
    check("rst_tdata", int'(tdata_o), 0);
    check("rst_mem_addr", int'(mem_addr_o), 0);

    // Reset in the middle of a sweep.
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 8'h20; len_i = 9'd8; tready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (tvalid_o) seen = 1;
      @(posedge clk); #1;
    end
    check("midsweep_saw_beat", seen, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", int'(tvalid_o), 0);
    check("midrst_tdata", int'(tdata_o), 0);
    check("midrst_tlast", int'(tlast_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_mem_addr", int'(mem_addr_o), 0);
    vbad = 0;
    repeat (6) begin
      @(negedge clk);
      if (tvalid_o || busy_o || done_o) vbad++;
    end
    check("midrst_quiet", vbad, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
